// File: rtl/mx2_rr_arbiter_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mx2_rr_arbiter_pkg                                                   |
// | Shared state encodings and default parameters for mx2_rr_arbiter.    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package mx2_rr_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        G0   = 2'b01,
        G1   = 2'b10
    } arb_state_t;

    localparam int c_DEFAULT_WIDTH    = 8;
    localparam int c_DEFAULT_MAX_HOLD = 4;

endpackage
`default_nettype wire

// File: rtl/_mx2.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | _mx2                                                                 |
// | Single-bit 2:1 multiplexer cell (s=0 selects d0).                    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module _mx2 (
    input  logic d0,
    input  logic d1,
    input  logic s,
    output logic y
);

    assign y = s ? d1 : d0;

endmodule
`default_nettype wire

// File: rtl/mx2_bus.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mx2_bus                                                              |
// | WIDTH-wide 2:1 multiplexer built from one _mx2 cell per bit.         |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module mx2_bus #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] d0,
    input  logic [WIDTH-1:0] d1,
    input  logic             s,
    output logic [WIDTH-1:0] y
);

    generate
        for (genvar i = 0; i < WIDTH; i++) begin : g_bit
            _mx2 u_mx2 (
                .d0 (d0[i]),
                .d1 (d1[i]),
                .s  (s),
                .y  (y[i])
            );
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/mx2_rr_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mx2_rr_arbiter                                                       |
// | Two-requester round-robin arbiter with hold cap driving a 2:1 mux.   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module mx2_rr_arbiter
    import mx2_rr_arbiter_pkg::*;
#(
    parameter int WIDTH    = c_DEFAULT_WIDTH,
    parameter int MAX_HOLD = c_DEFAULT_MAX_HOLD
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req0,
    input  logic             req1,
    input  logic [WIDTH-1:0] d0,
    input  logic [WIDTH-1:0] d1,
    output logic             gnt0,
    output logic             gnt1,
    output logic             sel,
    output logic [WIDTH-1:0] y,
    output logic             y_valid
);

    localparam int CNT_W = $clog2(MAX_HOLD) + 1;
    localparam logic [CNT_W-1:0] c_HOLD_LAST = CNT_W'(MAX_HOLD - 1);

    arb_state_t       r_state;
    arb_state_t       w_state_nxt;
    logic             r_sel;
    logic             r_last;
    logic [CNT_W-1:0] r_hold_cnt;
    logic             w_hold_expired;
    logic             w_other_waiting;

    assign w_hold_expired  = (r_hold_cnt == c_HOLD_LAST);
    assign w_other_waiting = ((r_state == G0) && req1) || ((r_state == G1) && req0);

    // A dropped request always wins over preemption; both lead to the same target.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (req0 && req1)  w_state_nxt = r_last ? G0 : G1;
                else if (req0)     w_state_nxt = G0;
                else if (req1)     w_state_nxt = G1;
            end
            G0: begin
                if (!req0)                          w_state_nxt = req1 ? G1 : IDLE;
                else if (req1 && w_hold_expired)    w_state_nxt = G1;
            end
            G1: begin
                if (!req1)                          w_state_nxt = req0 ? G0 : IDLE;
                else if (req0 && w_hold_expired)    w_state_nxt = G0;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= IDLE;
            r_sel      <= 1'b0;
            r_last     <= 1'b1;
            r_hold_cnt <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_state_nxt != r_state) begin
                r_hold_cnt <= '0;
            end else if (w_other_waiting && !w_hold_expired) begin
                r_hold_cnt <= r_hold_cnt + 1'b1;
            end
            // sel and last follow the granted side; IDLE leaves both untouched.
            if (w_state_nxt == G0) begin
                r_sel  <= 1'b0;
                r_last <= 1'b0;
            end else if (w_state_nxt == G1) begin
                r_sel  <= 1'b1;
                r_last <= 1'b1;
            end
        end
    end

    assign gnt0    = (r_state == G0);
    assign gnt1    = (r_state == G1);
    assign sel     = r_sel;
    assign y_valid = gnt0 | gnt1;

    mx2_bus #(
        .WIDTH (WIDTH)
    ) u_bus (
        .d0 (d0),
        .d1 (d1),
        .s  (r_sel),
        .y  (y)
    );

endmodule
`default_nettype wire

// File: tb/tb_mx2_rr_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_mx2_rr_arbiter                                                    |
// | Self-checking bench: owner-based reference model plus directed runs. |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_mx2_rr_arbiter;

    localparam int WIDTH    = 8;
    localparam int MAX_HOLD = 4;

    logic             clk   = 1'b0;
    logic             reset = 1'b1;
    logic             req0  = 1'b0;
    logic             req1  = 1'b0;
    logic [WIDTH-1:0] d0    = '0;
    logic [WIDTH-1:0] d1    = '0;
    logic             gnt0;
    logic             gnt1;
    logic             sel;
    logic [WIDTH-1:0] y;
    logic             y_valid;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: who owns the path, how long the other side has waited.
    int   m_owner = -1;
    int   m_last  = 1;
    int   m_held  = 0;
    logic m_sel   = 1'b0;

    mx2_rr_arbiter #(
        .WIDTH    (WIDTH),
        .MAX_HOLD (MAX_HOLD)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .req0    (req0),
        .req1    (req1),
        .d0      (d0),
        .d1      (d1),
        .gnt0    (gnt0),
        .gnt1    (gnt1),
        .sel     (sel),
        .y       (y),
        .y_valid (y_valid)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    initial begin
        forever begin
            @(posedge clk or posedge reset);
            if (reset) begin
                m_owner = -1;
                m_last  = 1;
                m_held  = 0;
                m_sel   = 1'b0;
            end else begin
                int   nxt;
                logic r [2];
                r[0] = req0;
                r[1] = req1;
                nxt  = m_owner;
                if (m_owner < 0) begin
                    if (r[0] && r[1]) nxt = 1 - m_last;
                    else if (r[0])    nxt = 0;
                    else if (r[1])    nxt = 1;
                end else if (!r[m_owner]) begin
                    nxt = r[1 - m_owner] ? 1 - m_owner : -1;
                end else if (r[1 - m_owner] && m_held >= MAX_HOLD - 1) begin
                    nxt = 1 - m_owner;
                end
                if (nxt != m_owner) begin
                    m_held = 0;
                    if (nxt >= 0) begin
                        m_last = nxt;
                        m_sel  = (nxt == 1);
                    end
                end else if (m_owner >= 0 && r[1 - m_owner]) begin
                    m_held++;
                end
                m_owner = nxt;
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            chk("model_gnt0", 32'(gnt0), 32'(m_owner == 0));
            chk("model_gnt1", 32'(gnt1), 32'(m_owner == 1));
            chk("model_sel", 32'(sel), 32'(m_sel));
            chk("model_valid", 32'(y_valid), 32'(m_owner >= 0));
            if (m_owner >= 0) chk("model_y", 32'(y), 32'(m_sel ? d1 : d0));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        #1;
        reset = 1'b0;
    endtask

    initial begin
        // Reset with no clock edge yet.
        #1;
        chk("rst_gnt0", 32'(gnt0), 32'd0);
        chk("rst_gnt1", 32'(gnt1), 32'd0);
        chk("rst_sel", 32'(sel), 32'd0);
        chk("rst_valid", 32'(y_valid), 32'd0);
        step();
        reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            chk("idle_valid", 32'(y_valid), 32'd0);
        end

        // Single requester.
        d0   = 8'hA5;
        req0 = 1'b1;
        step();
        chk("single_gnt0", 32'(gnt0), 32'd1);
        chk("single_y", 32'(y), 32'hA5);
        chk("single_valid", 32'(y_valid), 32'd1);
        req0 = 1'b0;
        step();
        chk("drop_gnt0", 32'(gnt0), 32'd0);
        chk("drop_valid", 32'(y_valid), 32'd0);

        // First tie goes to requester 0; handover without idle bubble.
        pulse_reset();
        req0 = 1'b1;
        req1 = 1'b1;
        d1   = 8'h3C;
        step();
        chk("tie_gnt0", 32'(gnt0), 32'd1);
        req0 = 1'b0;
        step();
        chk("handover_gnt1", 32'(gnt1), 32'd1);
        chk("handover_sel", 32'(sel), 32'd1);
        chk("handover_y", 32'(y), 32'h3C);

        // Sustained contention alternates every MAX_HOLD cycles.
        req1 = 1'b0;
        pulse_reset();
        req0 = 1'b1;
        req1 = 1'b1;
        step();
        for (int k = 0; k < 20; k++) begin
            chk("rr_gnt0", 32'(gnt0), 32'(((k / MAX_HOLD) % 2) == 0));
            chk("rr_gnt1", 32'(gnt1), 32'(((k / MAX_HOLD) % 2) == 1));
            step();
        end

        // Drop of the holder hands over and restarts the hold count.
        req0 = 1'b0;
        req1 = 1'b1;
        pulse_reset();
        step();
        chk("g1_gnt1", 32'(gnt1), 32'd1);
        req0 = 1'b1;
        step();
        step();
        req1 = 1'b0;
        step();
        chk("swap_gnt0", 32'(gnt0), 32'd1);
        req1 = 1'b1;
        for (int k = 0; k < MAX_HOLD - 1; k++) begin
            step();
            chk("restart_gnt0", 32'(gnt0), 32'd1);
        end
        step();
        chk("restart_gnt1", 32'(gnt1), 32'd1);
        req1 = 1'b0;
        step();
        chk("back_gnt0", 32'(gnt0), 32'd1);
        reset = 1'b1;
        #1;
        chk("async_gnt0", 32'(gnt0), 32'd0);
        chk("async_valid", 32'(y_valid), 32'd0);
        reset = 1'b0;
        req1  = 1'b1;
        step();
        chk("post_rst_gnt0", 32'(gnt0), 32'd1);

        // Randomized traffic, with occasional async reset pulses.
        for (int i = 0; i < 400; i++) begin
            req0 = ($urandom_range(0, 3) != 0);
            req1 = ($urandom_range(0, 3) != 0);
            d0   = WIDTH'($urandom);
            d1   = WIDTH'($urandom);
            if ($urandom_range(0, 49) == 0) begin
                reset = 1'b1;
                #2;
                reset = 1'b0;
            end
            step();
        end

        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
